mips_imem_sequencer: RTL and testbench
======================================

// Module: mips_imem_sequencer
// PURPOSE
//  Loadable, parametrised instruction-stream source for the MIPS core's iCache read port.
//  Stream mode: each loaded word is held on iCacheReadData for HOLD_CYCLES clocks.
//  Address mode: serves mem[iCacheReadAddr>>2] with 1-cycle latency.
//  Signals completion on done, replacing the fixed timed-stimulus sequences in core-level benches.
// PARAMETERS
//  DATA_W      32      instruction word width
//  DEPTH       16      words of program storage; power of 2, >=2; AW = $clog2(DEPTH)
//  HOLD_CYCLES 10      stream mode: clocks each word is presented; >=1
//  NOP_WORD    32'h0   value driven when not serving a program word
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       reset; asynchronous, active-low
//  loadEn          in   1       write loadData to mem[loadAddr]
//  loadAddr        in   AW      program word index
//  loadData        in   DATA_W  program word
//  progLen         in   AW+1    valid words, 0..DEPTH; sampled on accepted start
//  mode            in   1       0 = stream, 1 = address; sampled on accepted start
//  start           in   1       begin run (pulse)
//  iCacheReadAddr  in   32      core fetch byte address; used in address mode only
//  iCacheReadData  out  DATA_W  instruction to core, registered
//  instrIdx        out  AW      index of the word currently presented
//  busy            out  1       high in RUN
//  done            out  1       high in DONE; sticky until next accepted start
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; iCacheReadData=NOP_WORD; instrIdx=0; busy=0; done=0.
//    holdCnt=0. mem is not reset; contents survive reset.
//  - FSM states: IDLE, RUN, DONE.
//  - Load: loadEn in IDLE/DONE writes mem on the clock edge. loadEn in RUN is dropped.
//  - Start: accepted in IDLE/DONE when loadEn=0.
//    If start and loadEn are both high, the load is done and start is ignored.
//    start in RUN is ignored.
//    Accepted start latches len=progLen and mode; clears done, instrIdx and holdCnt.
//    len==0 -> DONE next cycle; iCacheReadData=NOP_WORD.
//    Otherwise -> RUN.
//  - Stream RUN:
//    - Cycle after start: iCacheReadData=mem[0], busy=1.
//    - holdCnt counts 0..HOLD_CYCLES-1. At terminal count with instrIdx<len-1:
//      instrIdx++ and the next word appears on the following cycle.
//    - At terminal count with instrIdx==len-1: -> DONE.
//    - RUN lasts exactly len*HOLD_CYCLES cycles.
//  - Address RUN:
//    - Each cycle wi = iCacheReadAddr[AW+1:2]. iCacheReadAddr[1:0] is ignored.
//    - In range means iCacheReadAddr[31:AW+2]==0 and wi<len.
//    - In range: next cycle iCacheReadData=mem[wi], instrIdx=wi.
//    - Out of range: next cycle iCacheReadData=NOP_WORD and -> DONE (end of program fetched).
//  - DONE: iCacheReadData=NOP_WORD; busy=0; done=1; instrIdx holds the last value.
//  - Reset asserted mid-run: immediate return to the reset values; the program is retained.
//  - Width: progLen>DEPTH is clamped to DEPTH on latch.
// CONFIGURATION
//  IMEM_CYCLE_CNT_EN defined:
//    - Adds output runCycles [31:0]: cleared on accepted start.
//    - Increments once per RUN cycle; holds in DONE; saturates at 32'hFFFF_FFFF.
//    - Reset value 0.
//  IMEM_CYCLE_CNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1 Load 014B4820, 014B4824, 014B4825, 014B4825; progLen=4, mode=0, HOLD=10, start
//    -> each word is held 10 cycles in order; busy=1 for 40 cycles; done=1 on cycle 41 with data=0.
//  2 Same program, mode=1: addr 0x8 -> 014B4825 next cycle, instrIdx=2;
//    addr 0x0 -> 014B4820; addr 0x10 -> data 0 and done=1 next cycle.
//  3 progLen=0, start -> done=1 the next cycle, busy never high.
//    Then start with progLen=2 -> done clears and RUN begins.
//  4 rst=0 during stream RUN at instrIdx=2 -> data=0, busy=0, done=0 asynchronously.
//    Restart after rst=1 replays the same words.
//  5 loadEn with 0xDEADBEEF to word 1 during RUN -> word 1 is unchanged.
//    loadEn+start together in IDLE -> word is written, state stays IDLE.
//  6 IMEM_CYCLE_CNT_EN: scenario 1 -> runCycles=40 in DONE; a second start clears it to 0.

Source files
------------

// File: rtl/mips_imem_sequencer_if.sv
// Bus between mips_imem_sequencer (slave) and its driver (program loader plus core fetch port).
// runCycles is present only when IMEM_CYCLE_CNT_EN is defined.
interface mips_imem_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
);
   localparam int AW = $clog2(DEPTH);

   logic              loadEn;
   logic [AW-1:0]     loadAddr;
   logic [DATA_W-1:0] loadData;
   logic [AW:0]       progLen;
   logic              mode;
   logic              start;
   logic [31:0]       iCacheReadAddr;
   logic [DATA_W-1:0] iCacheReadData;
   logic [AW-1:0]     instrIdx;
   logic              busy;
   logic              done;
`ifdef IMEM_CYCLE_CNT_EN
   logic [31:0]       runCycles;

   modport master (
      output loadEn, loadAddr, loadData, progLen, mode, start, iCacheReadAddr,
      input  iCacheReadData, instrIdx, busy, done, runCycles
   );
   modport slave (
      input  loadEn, loadAddr, loadData, progLen, mode, start, iCacheReadAddr,
      output iCacheReadData, instrIdx, busy, done, runCycles
   );
`else
   modport master (
      output loadEn, loadAddr, loadData, progLen, mode, start, iCacheReadAddr,
      input  iCacheReadData, instrIdx, busy, done
   );
   modport slave (
      input  loadEn, loadAddr, loadData, progLen, mode, start, iCacheReadAddr,
      output iCacheReadData, instrIdx, busy, done
   );
`endif
endinterface

// File: rtl/mips_imem_sequencer.sv
// Loadable instruction source for the core's iCache read port: stream mode holds each word
// HOLD_CYCLES clocks, address mode serves mem[addr>>2]. IMEM_CYCLE_CNT_EN adds runCycles.
module mips_imem_sequencer #(
   parameter int                DATA_W      = 32,
   parameter int                DEPTH       = 16,
   parameter int                HOLD_CYCLES = 10,
   parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
   input logic                  clk,
   input logic                  rst,
   mips_imem_sequencer_if.slave bus
);
   localparam int             AW        = $clog2(DEPTH);
   localparam int             HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [AW:0]    DEPTH_LEN = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_data;
   logic [AW-1:0]     r_idx;
   logic [AW:0]       r_len;
   logic              r_mode;
   logic [HW-1:0]     r_holdCnt;

   logic              w_loadAcc;
   logic              w_startAcc;
   logic [AW:0]       w_lenClamp;
   logic              w_holdLast;
   logic              w_lastWord;
   logic [AW-1:0]     w_nextIdx;
   logic [AW-1:0]     w_wordIdx;
   logic              w_inRange;

   // A simultaneous load wins over start, and neither is honoured while running.
   assign w_loadAcc  = bus.loadEn && (r_state != RUN);
   assign w_startAcc = bus.start && !bus.loadEn && (r_state != RUN);
   assign w_lenClamp = (bus.progLen > DEPTH_LEN) ? DEPTH_LEN : bus.progLen;
   assign w_holdLast = (r_holdCnt == HOLD_LAST);
   assign w_lastWord = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
   assign w_nextIdx  = r_idx + AW'(1);
   assign w_wordIdx  = bus.iCacheReadAddr[AW+1:2];
   assign w_inRange  = (bus.iCacheReadAddr[31:AW+2] == '0) && ({1'b0, w_wordIdx} < r_len);

   always_ff @(posedge clk) begin
      if (w_loadAcc) begin
         r_mem[bus.loadAddr] <= bus.loadData;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_startAcc) begin
               w_nextState = (w_lenClamp == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (r_mode) begin
               if (!w_inRange) begin
                  w_nextState = DONE;
               end
            end else if (w_holdLast && w_lastWord) begin
               w_nextState = DONE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Presented word, index and hold counter; the program store itself is never reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data    <= NOP_WORD;
         r_idx     <= '0;
         r_len     <= '0;
         r_mode    <= 1'b0;
         r_holdCnt <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_startAcc) begin
                  r_len     <= w_lenClamp;
                  r_mode    <= bus.mode;
                  r_idx     <= '0;
                  r_holdCnt <= '0;
                  r_data    <= ((w_lenClamp != '0) && !bus.mode) ? r_mem[0] : NOP_WORD;
               end
            end
            RUN: begin
               if (r_mode) begin
                  if (w_inRange) begin
                     r_data <= r_mem[w_wordIdx];
                     r_idx  <= w_wordIdx;
                  end else begin
                     r_data <= NOP_WORD;
                  end
               end else if (w_holdLast) begin
                  r_holdCnt <= '0;
                  if (w_lastWord) begin
                     r_data <= NOP_WORD;
                  end else begin
                     r_idx  <= w_nextIdx;
                     r_data <= r_mem[w_nextIdx];
                  end
               end else begin
                  r_holdCnt <= r_holdCnt + HW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy           = (r_state == RUN);
      bus.done           = (r_state == DONE);
      bus.iCacheReadData = r_data;
      bus.instrIdx       = r_idx;
   end

`ifdef IMEM_CYCLE_CNT_EN
   logic [31:0] r_runCycles;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_runCycles <= '0;
      end else if (w_startAcc) begin
         r_runCycles <= '0;
      end else if ((r_state == RUN) && (r_runCycles != 32'hFFFF_FFFF)) begin
         r_runCycles <= r_runCycles + 32'd1;
      end
   end

   assign bus.runCycles = r_runCycles;
`endif
endmodule

// File: tb/tb_mips_imem_sequencer.sv
// Scoreboard bench for mips_imem_sequencer: stimulus pushes per-cycle expectations from a
// behavioural model, a monitor pops and compares them after every rising edge.
module tb_mips_imem_sequencer;
   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 16;
   localparam int          AW     = 4;
   localparam int          HOLD   = 10;
   localparam logic [31:0] NOP    = 32'h0;

   typedef struct {
      logic [31:0] data;
      int          idx;
      bit          busy;
      bit          done;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   exp_t        expQ[$];
   exp_t        monE;
   logic [31:0] model[DEPTH];
   int          mIdx = 0;
   bit          mDone = 1'b0;
   int          mCyc = 0;
   int          compared = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   mips_imem_sequencer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   mips_imem_sequencer #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .NOP_WORD(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Every edge that the stimulus announced is checked against its expectation.
   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput("data", bus.iCacheReadData, monE.data);
         checkOutput("instrIdx", 32'(bus.instrIdx), 32'(monE.idx));
         checkOutput("busy", 32'(bus.busy), 32'(monE.busy));
         checkOutput("done", 32'(bus.done), 32'(monE.done));
`ifdef IMEM_CYCLE_CNT_EN
         checkOutput("runCycles", bus.runCycles, 32'(monE.cyc));
`endif
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic idleInputs();
      bus.loadEn = 1'b0; bus.loadAddr = '0; bus.loadData = '0; bus.progLen = '0;
      bus.mode = 1'b0; bus.start = 1'b0; bus.iCacheReadAddr = '0;
   endtask

   task automatic noiseInputs();
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.loadEn   = ($urandom_range(0, 5) == 0);
      bus.loadAddr = AW'($urandom);
      bus.loadData = $urandom;
      bus.progLen  = (AW+1)'($urandom);
      bus.mode     = 1'($urandom);
   endtask

   // Announce the outcome of the coming edge, then move to the next falling edge.
   task automatic applyStimulus(input bit push, input exp_t e);
      if (push) expQ.push_back(e);
      @(negedge clk);
   endtask

   function automatic exp_t restExp();
      exp_t e;
      e = '{NOP, mIdx, 1'b0, mDone, mCyc};
      return e;
   endfunction

   function automatic int clampLen(input int len);
      return (len > DEPTH) ? DEPTH : len;
   endfunction

   task automatic loadWord(input int a, input logic [31:0] d);
      bus.loadEn = 1'b1; bus.loadAddr = AW'(a); bus.loadData = d; bus.start = 1'b0;
      model[a] = d;
      applyStimulus(1'b1, restExp());
      bus.loadEn = 1'b0;
   endtask

   task automatic pulseReset();
      idleInputs();
      rst = 1'b0;
      #1;
      checkOutput("reset data", bus.iCacheReadData, NOP);
      checkOutput("reset instrIdx", 32'(bus.instrIdx), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset done", 32'(bus.done), 32'd0);
`ifdef IMEM_CYCLE_CNT_EN
      checkOutput("reset runCycles", bus.runCycles, 32'd0);
`endif
      mIdx = 0; mDone = 1'b0; mCyc = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Stream run: edge k after start shows word k/HOLD; abortAt >= 0 resets after that edge.
   task automatic runStream(input int len, input int abortAt);
      int L;
      L = clampLen(len);
      bus.progLen = (AW+1)'(len); bus.mode = 1'b0; bus.start = 1'b1; bus.loadEn = 1'b0;
      mIdx = 0; mCyc = 0;
      if (L == 0) begin
         mDone = 1'b1;
         applyStimulus(1'b1, restExp());
         idleInputs();
         return;
      end
      mDone = 1'b0;
      for (int k = 0; k < L * HOLD; k++) begin
         applyStimulus(1'b1, '{model[k / HOLD], k / HOLD, 1'b1, 1'b0, k});
         noiseInputs();
         if (k == 0) begin
            bus.loadEn = 1'b1; bus.loadAddr = AW'(1); bus.loadData = 32'hDEADBEEF;
         end
         if (k == abortAt) begin
            pulseReset();
            return;
         end
      end
      mDone = 1'b1; mIdx = L - 1; mCyc = L * HOLD;
      applyStimulus(1'b1, restExp());
      idleInputs();
   endtask

   // Address run: each fetch address is served next edge if addr>>2 < len, else the run ends.
   task automatic runAddr(input int len, input logic [31:0] addrs[$]);
      int L;
      L = clampLen(len);
      bus.progLen = (AW+1)'(len); bus.mode = 1'b1; bus.start = 1'b1; bus.loadEn = 1'b0;
      mIdx = 0; mCyc = 0;
      if (L == 0) begin
         mDone = 1'b1;
         applyStimulus(1'b1, restExp());
         idleInputs();
         return;
      end
      mDone = 1'b0;
      applyStimulus(1'b1, '{NOP, 0, 1'b1, 1'b0, 0});
      for (int j = 0; j < addrs.size(); j++) begin
         noiseInputs();
         bus.iCacheReadAddr = addrs[j];
         if ((addrs[j] >> 2) < L) begin
            mIdx = int'(addrs[j] >> 2);
            applyStimulus(1'b1, '{model[mIdx], mIdx, 1'b1, 1'b0, j + 1});
         end else begin
            mDone = 1'b1; mCyc = j + 1;
            applyStimulus(1'b1, restExp());
            break;
         end
      end
      idleInputs();
   endtask

   function automatic logic [31:0] genAddr(input int L);
      if (L == 0 || $urandom_range(0, 7) == 0) return $urandom;
      return (32'($urandom_range(0, L - 1)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [31:0] aq[$];
      int          len;
      idleInputs();
      @(negedge clk);
      checkOutput("por data", bus.iCacheReadData, NOP);
      checkOutput("por instrIdx", 32'(bus.instrIdx), 32'd0);
      checkOutput("por busy", 32'(bus.busy), 32'd0);
      checkOutput("por done", 32'(bus.done), 32'd0);
      rst = 1'b1;

      for (int w = 0; w < DEPTH; w++) loadWord(w, $urandom);
      loadWord(0, 32'h014B4820);
      loadWord(1, 32'h014B4824);
      loadWord(2, 32'h014B4825);
      loadWord(3, 32'h014B4825);

      runStream(4, -1);
      repeat (2) applyStimulus(1'b1, restExp());

      aq = {32'h8, 32'h0, 32'h10};
      runAddr(4, aq);
      applyStimulus(1'b1, restExp());

      runStream(0, -1);
      repeat (2) applyStimulus(1'b1, restExp());
      runStream(2, -1);

      runStream(4, 25);
      runStream(4, -1);
      pulseReset();

      bus.loadEn = 1'b1; bus.start = 1'b1; bus.progLen = 5'd4;
      bus.loadAddr = AW'(3); bus.loadData = 32'hCAFE0003;
      model[3] = 32'hCAFE0003;
      applyStimulus(1'b1, restExp());
      idleInputs();
      applyStimulus(1'b1, restExp());
      aq = {32'hC, 32'h5, 32'h0001_0000};
      runAddr(4, aq);

      for (int it = 0; it < 24; it++) begin
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) loadWord($urandom_range(0, DEPTH - 1), $urandom);
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * DEPTH - 1) : $urandom_range(1, 5);
         if ($urandom_range(0, 1) == 0) begin
            runStream(len, -1);
         end else begin
            aq = {};
            for (int n = 0; n < int'($urandom_range(1, 12)); n++) aq.push_back(genAddr(clampLen(len)));
            aq.push_back(32'h8000_0000 | 32'($urandom_range(0, 255)));
            runAddr(len, aq);
         end
         for (int r = 0; r < int'($urandom_range(0, 2)); r++) applyStimulus(1'b1, restExp());
      end

      repeat (3) @(negedge clk);
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
